// File: rtl/regfile_dbg_master.sv
// Debug initiator driving the register file's spare read port and write port.
// Optional build macro REGFILE_DBG_X0_PROTECT_EN makes register 0 write-protected.
module regfile_dbg_master #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3,
  parameter int NUM_REGS      = (1 << REGADDR_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [REGADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [REGADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_last,
  output logic                     rsp_err,
  output logic [REGADDR_WIDTH-1:0] rf_read_reg,
  input  logic [DATA_WIDTH-1:0]    rf_read_data,
  output logic [REGADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     rf_reg_write,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, DUMP_RD, DUMP_RESP} state_t;

  localparam logic [REGADDR_WIDTH:0]   NUM_REGS_W = (REGADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [REGADDR_WIDTH-1:0] LAST_REG   = REGADDR_WIDTH'(NUM_REGS - 1);

  state_t                     state_q;
  logic [REGADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       err_q;
  logic [REGADDR_WIDTH-1:0]   cnt_q;
  logic                       rsp_valid_q;
  logic                       rsp_last_q;
  logic                       rsp_err_q;
  logic [REGADDR_WIDTH-1:0]   rsp_addr_q;
  logic [DATA_WIDTH-1:0]      rsp_data_q;
  logic [REGADDR_WIDTH-1:0]   rf_read_reg_q;
  logic [REGADDR_WIDTH-1:0]   rf_write_reg_q;
  logic [DATA_WIDTH-1:0]      rf_write_data_q;
  logic                       rf_reg_write_q;

  logic oor_d;
  logic wr_err_d;

  assign oor_d = ({1'b0, cmd_addr} >= NUM_REGS_W);
`ifdef REGFILE_DBG_X0_PROTECT_EN
  assign wr_err_d = oor_d | (cmd_addr == '0);
`else
  assign wr_err_d = oor_d;
`endif

  assign cmd_ready     = (state_q == IDLE) && reset_n;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_last      = rsp_last_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_addr      = rsp_addr_q;
  assign rsp_data      = rsp_data_q;
  assign rf_read_reg   = rf_read_reg_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_reg_write  = rf_reg_write_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_last_q      <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_addr_q      <= '0;
      rsp_data_q      <= '0;
      rf_read_reg_q   <= '0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      rf_reg_write_q  <= 1'b0;
    end else begin
      rf_reg_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            case (cmd_op)
              2'b00: begin
                state_q       <= READ;
                rf_read_reg_q <= cmd_addr;
                err_q         <= oor_d;
              end
              2'b01: begin
                // The write strobe is launched here so it is live during the WRITE cycle.
                state_q         <= WRITE;
                err_q           <= wr_err_d;
                rf_reg_write_q  <= !wr_err_d;
                rf_write_reg_q  <= cmd_addr;
                rf_write_data_q <= cmd_wdata;
              end
              2'b10: begin
                state_q       <= DUMP_RD;
                cnt_q         <= '0;
                rf_read_reg_q <= '0;
              end
              default: ;
            endcase
          end
        end
        READ: begin
          rsp_data_q  <= err_q ? '0 : rf_read_data;
          rsp_addr_q  <= addr_q;
          rsp_err_q   <= err_q;
          rsp_last_q  <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        WRITE: begin
          rsp_data_q  <= wdata_q;
          rsp_addr_q  <= addr_q;
          rsp_err_q   <= err_q;
          rsp_last_q  <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DUMP_RD: begin
          rsp_data_q  <= rf_read_data;
          rsp_addr_q  <= cnt_q;
          rsp_err_q   <= 1'b0;
          rsp_last_q  <= (cnt_q == LAST_REG);
          rsp_valid_q <= 1'b1;
          state_q     <= DUMP_RESP;
        end
        DUMP_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q         <= cnt_q + 1'b1;
              rf_read_reg_q <= cnt_q + 1'b1;
              state_q       <= DUMP_RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_dbg_master.md
Name: regfile_dbg_master

Overview:
Debug-side initiator for the register file's two-read/one-write port set. It accepts single read, single write, or full-dump commands on a valid/ready command channel and sequences the matching register file port activity. It returns results on a valid/ready response channel. It sits between the debug transport and the register file's spare read port and its write port; the core is stalled externally while `busy` is high.

Parameters:
- DATA_WIDTH, 16, register data width.
- REGADDR_WIDTH, 3, register address width.
- NUM_REGS, (1<<REGADDR_WIDTH), number of implemented registers; must be ≤ 2^REGADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset; one clock, asynchronous and active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_op  input  2  00 read, 01 write, 10 dump, 11 reserved.
- cmd_addr  input  REGADDR_WIDTH  target register (read/write only).
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high with rsp_valid.
- rsp_addr  output  REGADDR_WIDTH  register the response refers to.
- rsp_data  output  DATA_WIDTH  read data, or echoed write data.
- rsp_last  output  1  final response of a command.
- rsp_err  output  1  command not performed (range or protection).
- rf_read_reg  output  REGADDR_WIDTH  register file read address.
- rf_read_data  input  DATA_WIDTH  register file read data (combinational from rf_read_reg).
- rf_write_reg  output  REGADDR_WIDTH  register file write address.
- rf_write_data  output  DATA_WIDTH  register file write data.
- rf_reg_write  output  1  register file write enable.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP, DUMP_RD, DUMP_RESP.
- cmd_ready = (state == IDLE). While reset_n is low, no command is accepted.
- IDLE, on handshake: latch op, addr and wdata.
  - Read goes to READ.
  - Write goes to WRITE.
  - Dump clears the counter to 0 and goes to DUMP_RD.
  - Reserved op is consumed with no response; stays IDLE.
- READ (1 cycle):
  - rf_read_reg = latched addr.
  - Capture rf_read_data into rsp_data, set rsp_addr = addr.
  - Go to RESP.
- WRITE (1 cycle):
  - rf_reg_write = 1, rf_write_reg = addr, rf_write_data = wdata.
  - rsp_data = wdata.
  - Go to RESP.
- RESP:
  - rsp_valid = 1, rsp_last = 1.
  - On rsp_ready, go to IDLE; rsp_valid deasserts the following cycle.
- DUMP_RD (1 cycle):
  - rf_read_reg = counter.
  - Capture rsp_data, set rsp_addr = counter.
  - Go to DUMP_RESP.
- DUMP_RESP:
  - rsp_valid = 1, rsp_last = (counter == NUM_REGS-1).
  - On rsp_ready: if last, go to IDLE; else counter+1 and go to DUMP_RD.
  - Throughput: at most one register every 2 cycles.
- Latency: command handshake at edge k means rf_reg_write/read occurs in cycle k..k+1, and rsp_valid is high from edge k+1.
- All rsp_* outputs and rf_write_* are registered. rf_reg_write is high for exactly one cycle per performed write.
- rsp_* must hold stable while rsp_valid && !rsp_ready.
- rf_read_reg holds its last value outside READ and DUMP_RD.
- Out of range (addr ≥ NUM_REGS):
  - Read returns rsp_data = 0 with rsp_err = 1.
  - Write suppresses rf_reg_write, rsp_data = wdata, rsp_err = 1.
  - Dump never goes out of range.
- Reset values: state IDLE, counter 0, rsp_valid 0, rsp_last 0, rsp_err 0, rsp_data 0, rsp_addr 0, rf_reg_write 0, rf_write_reg 0, rf_write_data 0, rf_read_reg 0, busy 0.
- Reset mid-operation: immediately aborts.
  - Pending response and write are dropped, and rf_reg_write drops asynchronously.
  - The next dump restarts at register 0.

Optional Feature:
- Macro: REGFILE_DBG_X0_PROTECT_EN.
- Defined: a write to address 0 never asserts rf_reg_write and responds with rsp_err = 1, rsp_data = wdata. Reads and dumps of register 0 are unaffected.
- Undefined: address 0 is written like any other register.

Test Plan:
- Write addr 3, data 0xBEEF: one-cycle rf_reg_write with rf_write_reg = 3, rf_write_data = 0xBEEF. Then rsp_valid with rsp_addr = 3, rsp_data = 0xBEEF, rsp_last = 1, rsp_err = 0.
- Regfile model holds reg3 = 0xBEEF; read addr 3: rf_read_reg = 3, rsp_data = 0xBEEF, rsp_last = 1, rsp_valid rises one edge after accept.
- Regs i = 0x1000+i, dump with rsp_ready toggling every cycle: 8 responses, rsp_addr 0..7 in order, data 0x1000..0x1007, rsp_last only on addr 7, cmd_ready = 0 and busy = 1 throughout, no rf_reg_write.
- Read with rsp_ready held low for 5 cycles: rsp_valid and rsp_data stable all 5 cycles, a new cmd_valid is not accepted, accepted one cycle after the response handshake.
- reset_n pulsed low during DUMP_RESP at addr 4: rsp_valid and busy go to 0 asynchronously. A subsequent dump starts at rsp_addr = 0.
- Write addr 0, data 0x1234: with REGFILE_DBG_X0_PROTECT_EN, no rf_reg_write and rsp_err = 1. Without it, rf_reg_write pulses and rsp_err = 0.
